// File: rtl/hsi_s_rx_frame_ctrl.sv
// hsi_s_rx_frame_ctrl: parses flag/length/payload/CRC receive frames, buffers the payload and holds it for a consumer.
module hsi_s_rx_frame_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] d,
  input  logic       d_rdy,
  input  logic       frame_end,
  input  logic [5:0] rx_errs,
  output logic       frm_valid,
  output logic [7:0] frm_flag,
  output logic [7:0] frm_len,
  input  logic       frm_ack,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_empty,
  output logic       err_strb,
  output logic [2:0] err_code,
  output logic       busy
);
  localparam int AW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CRC, END, HOLD, DROP} state_t;
  state_t state, nxt;
  logic [7:0] mem [2**AW];
  logic [7:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tcnt;
  logic crc_cnt, ovr, ovr_n, err_set, flag_we, len_we, wr_we, counting;
  logic [2:0] code;
  assign counting = state inside {LEN, PAYLOAD, CRC, END, DROP};
  assign frm_valid = state == HOLD;
  assign busy = state != IDLE;
  assign rd_empty = state != HOLD || rd_ptr == frm_len;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  // The byte is applied first; frame_end then acts on the state the byte produced.
  always_comb begin
    nxt = state;
    ovr_n = ovr;
    err_set = 1'b0;
    code = 3'd0;
    flag_we = 1'b0;
    len_we = 1'b0;
    wr_we = 1'b0;
    if (d_rdy)
      case (state)
        IDLE: begin flag_we = 1'b1; nxt = LEN; end
        LEN: begin
          len_we = 1'b1;
          nxt = (d == 8'd0) ? CRC : (d <= 8'(MAX_LEN)) ? PAYLOAD : DROP;
          if (d > 8'(MAX_LEN)) begin err_set = 1'b1; code = 3'd3; end
        end
        PAYLOAD: begin wr_we = 1'b1; if (wr_ptr + 8'd1 == frm_len) nxt = CRC; end
        CRC: if (crc_cnt) nxt = END;
        END: begin err_set = 1'b1; code = 3'd2; nxt = DROP; end
        HOLD: if (!ovr) begin err_set = 1'b1; code = 3'd6; ovr_n = 1'b1; end
        default: ;
      endcase
    if (frame_end)
      case (nxt)
        LEN, PAYLOAD, CRC: begin err_set = 1'b1; code = 3'd1; nxt = IDLE; end
        END: if (rx_errs == 6'd0) nxt = HOLD; else begin err_set = 1'b1; code = 3'd4; nxt = IDLE; end
        HOLD: ovr_n = 1'b0;
        DROP: nxt = IDLE;
        default: ;
      endcase
    else if (!d_rdy && counting && clk_en && tcnt == TW'(TIMEOUT - 1)) begin
      err_set = 1'b1;
      code = 3'd5;
      nxt = IDLE;
    end
    // An ack mid-overrun still has to swallow the rest of the overrunning frame.
    if (state == HOLD && frm_ack) begin
      nxt = ovr_n ? DROP : IDLE;
      ovr_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      frm_flag <= 8'd0;
      frm_len <= 8'd0;
      wr_ptr <= 8'd0;
      rd_ptr <= 8'd0;
      tcnt <= '0;
      crc_cnt <= 1'b0;
      ovr <= 1'b0;
      err_strb <= 1'b0;
      err_code <= 3'd0;
    end else begin
      state <= nxt;
      ovr <= ovr_n;
      err_strb <= err_set;
      if (err_set) err_code <= code;
      if (flag_we) frm_flag <= d;
      if (len_we) frm_len <= d;
      wr_ptr <= (err_set || nxt == IDLE || nxt == DROP) ? 8'd0 : wr_ptr + {7'd0, wr_we};
      rd_ptr <= (state != HOLD || frm_ack) ? 8'd0 : rd_ptr + {7'd0, rd_en && !rd_empty};
      tcnt <= (d_rdy || !counting) ? '0 : tcnt + TW'(clk_en);
      crc_cnt <= state == CRC && (crc_cnt ^ d_rdy);
    end
  always_ff @(posedge clk)
    if (wr_we) mem[wr_ptr[AW-1:0]] <= d;
endmodule

// File: tb/tb_hsi_s_rx_frame_ctrl.sv
// tb_hsi_s_rx_frame_ctrl: directed scenarios plus random frames checked against a frame-level outcome model.
module tb_hsi_s_rx_frame_ctrl;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 1023;
  logic clk = 0, rst = 1, clk_en = 0, d_rdy = 0, frame_end = 0, frm_ack = 0, rd_en = 0;
  logic [7:0] d = 0;
  logic [5:0] rx_errs = 0;
  logic frm_valid, rd_empty, err_strb, busy;
  logic [7:0] frm_flag, frm_len, rd_data;
  logic [2:0] err_code;
  int checks = 0, failures = 0, err_cnt = 0;

  hsi_s_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .d(d), .d_rdy(d_rdy), .frame_end(frame_end),
    .rx_errs(rx_errs), .frm_valid(frm_valid), .frm_flag(frm_flag), .frm_len(frm_len),
    .frm_ack(frm_ack), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .err_strb(err_strb), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (err_strb) err_cnt++;

  // Outcome of one frame from its byte count, length byte and error vector: 0 = held, else error code.
  function automatic int predict(input int n, input int l, input logic [5:0] e);
    if (n < 2) return 1;
    if (l > MAX_LEN) return 3;
    if (n < l + 4) return 1;
    if (n > l + 4) return 2;
    if (e != 6'd0) return 4;
    return 0;
  endfunction

  task automatic drive(input logic dr, input logic [7:0] b, input logic fe, input logic [5:0] e,
                       input logic ack, input logic rd);
    d_rdy = dr; d = b; frame_end = fe; rx_errs = e; frm_ack = ack; rd_en = rd;
    @(negedge clk);
    d_rdy = 0; frame_end = 0; rx_errs = 0; frm_ack = 0; rd_en = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] q[$], input logic fe_same, input logic [5:0] e);
    foreach (q[i]) drive(1, q[i], fe_same && i == q.size() - 1, (fe_same && i == q.size() - 1) ? e : 6'd0, 0, 0);
    if (!fe_same) drive(0, 8'd0, 1, e, 0, 0);
  endtask

  task automatic test_reset;
    idle(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (frm_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", frm_valid); end
    checks++; if (rd_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0h exp=1", rd_empty); end
    checks++; if ({frm_flag, frm_len} !== 16'h0) begin failures++; $display("FAIL reset_flaglen got=%h exp=0000", {frm_flag, frm_len}); end
    checks++; if ({err_strb, err_code} !== 4'h0) begin failures++; $display("FAIL reset_err got=%h exp=0", {err_strb, err_code}); end
    rst = 0;
    idle(1);
  endtask

  task automatic test_basic;
    logic [7:0] q[$];
    logic [7:0] p[$];
    int base;
    base = err_cnt;
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'hC1, 8'hC2};
    p = '{8'h11, 8'h22, 8'h33};
    send(q, 0, 6'd0);
    checks++; if (frm_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0h exp=1", frm_valid); end
    checks++; if (frm_flag !== 8'hA5) begin failures++; $display("FAIL basic_flag got=%h exp=a5", frm_flag); end
    checks++; if (frm_len !== 8'h03) begin failures++; $display("FAIL basic_len got=%h exp=03", frm_len); end
    foreach (p[i]) begin
      checks++; if (rd_data !== p[i]) begin failures++; $display("FAIL basic_rd%0d got=%h exp=%h", i, rd_data, p[i]); end
      drive(0, 8'd0, 0, 6'd0, 0, 1);
    end
    checks++; if (rd_empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%0h exp=1", rd_empty); end
    drive(0, 8'd0, 0, 6'd0, 1, 0);
    checks++; if ({busy, frm_valid} !== 2'b00) begin failures++; $display("FAIL basic_ack got=%b exp=00", {busy, frm_valid}); end
    checks++; if (err_cnt !== base) begin failures++; $display("FAIL basic_noerr got=%0d exp=%0d", err_cnt, base); end
  endtask

  task automatic test_zero_len;
    logic [7:0] q[$];
    int base;
    base = err_cnt;
    q = '{8'h01, 8'h00, 8'hC1, 8'hC2};
    send(q, 1, 6'd0);
    checks++; if (frm_valid !== 1'b1) begin failures++; $display("FAIL zero_valid got=%0h exp=1", frm_valid); end
    checks++; if (frm_len !== 8'h00) begin failures++; $display("FAIL zero_len got=%h exp=00", frm_len); end
    checks++; if (rd_empty !== 1'b1) begin failures++; $display("FAIL zero_empty got=%0h exp=1", rd_empty); end
    drive(0, 8'd0, 0, 6'd0, 1, 0);
    idle(1);
    checks++; if (err_cnt !== base) begin failures++; $display("FAIL zero_noerr got=%0d exp=%0d", err_cnt, base); end
  endtask

  task automatic test_len_errors;
    logic [7:0] q[$];
    int base;
    base = err_cnt;
    drive(1, 8'h01, 0, 6'd0, 0, 0);
    drive(1, 8'h14, 0, 6'd0, 0, 0);
    idle(1);
    checks++; if (err_cnt !== base + 1) begin failures++; $display("FAIL big_pulses got=%0d exp=%0d", err_cnt, base + 1); end
    checks++; if (err_code !== 3'd3) begin failures++; $display("FAIL big_code got=%0d exp=3", err_code); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL big_drop got=%0h exp=1", busy); end
    drive(1, 8'h55, 0, 6'd0, 0, 0);
    drive(0, 8'd0, 1, 6'd0, 0, 0);
    idle(1);
    checks++; if ({busy, frm_valid} !== 2'b00) begin failures++; $display("FAIL big_end got=%b exp=00", {busy, frm_valid}); end
    checks++; if (err_cnt !== base + 1) begin failures++; $display("FAIL big_once got=%0d exp=%0d", err_cnt, base + 1); end
    q = '{8'h01, 8'h02, 8'hAA};
    send(q, 1, 6'd0);
    idle(1);
    checks++; if (err_code !== 3'd1) begin failures++; $display("FAIL short_code got=%0d exp=1", err_code); end
    checks++; if (err_cnt !== base + 2) begin failures++; $display("FAIL short_pulses got=%0d exp=%0d", err_cnt, base + 2); end
  endtask

  task automatic test_rx_err;
    logic [7:0] q[$];
    int base;
    base = err_cnt;
    q = '{8'h01, 8'h01, 8'h55, 8'hC1, 8'hC2};
    send(q, 0, 6'b000100);
    idle(1);
    checks++; if (err_code !== 3'd4) begin failures++; $display("FAIL rxerr_code got=%0d exp=4", err_code); end
    checks++; if (frm_valid !== 1'b0) begin failures++; $display("FAIL rxerr_valid got=%0h exp=0", frm_valid); end
    checks++; if (err_cnt !== base + 1) begin failures++; $display("FAIL rxerr_pulses got=%0d exp=%0d", err_cnt, base + 1); end
  endtask

  task automatic test_overrun;
    logic [7:0] q[$];
    logic [7:0] p[$];
    int base;
    q = '{8'h7E, 8'h02, 8'hDE, 8'hAD, 8'hC1, 8'hC2};
    p = '{8'hDE, 8'hAD};
    send(q, 0, 6'd0);
    base = err_cnt;
    q = '{8'h01, 8'h01, 8'h99, 8'hC1, 8'hC2};
    send(q, 0, 6'd0);
    idle(1);
    checks++; if (err_cnt !== base + 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=%0d", err_cnt, base + 1); end
    checks++; if (err_code !== 3'd6) begin failures++; $display("FAIL ovr_code got=%0d exp=6", err_code); end
    checks++; if ({frm_valid, frm_flag, frm_len} !== {1'b1, 8'h7E, 8'h02}) begin failures++; $display("FAIL ovr_held got=%h exp=17e02", {frm_valid, frm_flag, frm_len}); end
    foreach (p[i]) begin
      checks++; if (rd_data !== p[i]) begin failures++; $display("FAIL ovr_rd%0d got=%h exp=%h", i, rd_data, p[i]); end
      drive(0, 8'd0, 0, 6'd0, 0, 1);
    end
    checks++; if (rd_empty !== 1'b1) begin failures++; $display("FAIL ovr_empty got=%0h exp=1", rd_empty); end
    drive(0, 8'd0, 0, 6'd0, 1, 0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovr_ack got=%0h exp=0", busy); end
  endtask

  task automatic test_timeout;
    int base;
    clk_en = 1;
    drive(1, 8'h01, 0, 6'd0, 0, 0);
    drive(1, 8'h02, 0, 6'd0, 0, 0);
    base = err_cnt;
    idle(TIMEOUT - 1);
    checks++; if ({busy, err_strb} !== 2'b10) begin failures++; $display("FAIL tmo_early got=%b exp=10", {busy, err_strb}); end
    checks++; if (err_cnt !== base) begin failures++; $display("FAIL tmo_none got=%0d exp=%0d", err_cnt, base); end
    idle(1);
    checks++; if (err_strb !== 1'b1) begin failures++; $display("FAIL tmo_strb got=%0h exp=1", err_strb); end
    checks++; if (err_code !== 3'd5) begin failures++; $display("FAIL tmo_code got=%0d exp=5", err_code); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_idle got=%0h exp=0", busy); end
    clk_en = 0;
    idle(1);
  endtask

  task automatic test_reset_mid;
    logic [7:0] q[$];
    drive(1, 8'h01, 0, 6'd0, 0, 0);
    drive(1, 8'h04, 0, 6'd0, 0, 0);
    drive(1, 8'h11, 0, 6'd0, 0, 0);
    drive(1, 8'h22, 0, 6'd0, 0, 0);
    #2 rst = 1;
    #1;
    checks++; if ({busy, frm_valid, rd_empty} !== 3'b001) begin failures++; $display("FAIL rstmid_state got=%b exp=001", {busy, frm_valid, rd_empty}); end
    checks++; if ({frm_flag, frm_len, err_code} !== 19'h0) begin failures++; $display("FAIL rstmid_regs got=%h exp=0", {frm_flag, frm_len, err_code}); end
    @(negedge clk);
    rst = 0;
    q = '{8'h3C, 8'h01, 8'h77, 8'hC1, 8'hC2};
    send(q, 0, 6'd0);
    checks++; if ({frm_valid, frm_flag, frm_len, rd_data} !== {1'b1, 8'h3C, 8'h01, 8'h77}) begin failures++; $display("FAIL rstmid_next got=%h exp=13c0177", {frm_valid, frm_flag, frm_len, rd_data}); end
    drive(0, 8'd0, 0, 6'd0, 1, 0);
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] p[$];
    logic [7:0] flag;
    logic [5:0] e;
    logic fe_same;
    int l, n, exp, base;
    for (int k = 0; k < 40; k++) begin
      l = $urandom_range(0, 20);
      n = l + 2 + $urandom_range(0, 3);
      if (n < 1) n = 1;
      flag = 8'($urandom);
      e = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      fe_same = 1'($urandom);
      clk_en = 1'($urandom);
      q.delete();
      p.delete();
      for (int i = 0; i < n; i++) begin
        if (i == 0) q.push_back(flag);
        else if (i == 1) q.push_back(8'(l));
        else q.push_back(8'($urandom));
        if (i >= 2 && i < l + 2) p.push_back(q[i]);
      end
      exp = predict(n, l, e);
      base = err_cnt;
      send(q, fe_same, e);
      idle(1);
      if (exp == 0) begin
        checks++; if ({frm_valid, frm_flag, frm_len} !== {1'b1, flag, 8'(l)}) begin failures++; $display("FAIL rnd%0d_hdr got=%h exp=%h", k, {frm_valid, frm_flag, frm_len}, {1'b1, flag, 8'(l)}); end
        foreach (p[i]) begin
          checks++; if (rd_data !== p[i]) begin failures++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", k, i, rd_data, p[i]); end
          drive(0, 8'd0, 0, 6'd0, 0, 1);
        end
        checks++; if (rd_empty !== 1'b1) begin failures++; $display("FAIL rnd%0d_empty got=%0h exp=1", k, rd_empty); end
        checks++; if (err_cnt !== base) begin failures++; $display("FAIL rnd%0d_noerr got=%0d exp=%0d", k, err_cnt, base); end
        drive(0, 8'd0, 0, 6'd0, 1, 0);
      end else begin
        checks++; if (err_cnt !== base + 1) begin failures++; $display("FAIL rnd%0d_pulses got=%0d exp=%0d", k, err_cnt, base + 1); end
        checks++; if (err_code !== 3'(exp)) begin failures++; $display("FAIL rnd%0d_code got=%0d exp=%0d", k, err_code, exp); end
        checks++; if ({busy, frm_valid} !== 2'b00) begin failures++; $display("FAIL rnd%0d_idle got=%b exp=00", k, {busy, frm_valid}); end
      end
    end
    clk_en = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_len;
    test_len_errors;
    test_rx_err;
    test_overrun;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
